// File: rtl/prescaler_pkg.sv
// Shared types for the prescaler bank: channel run mode and channel state.
package prescaler_pkg;

   typedef enum logic {
      PERIODIC = 1'b0,
      ONE_SHOT = 1'b1
   } mode_t;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/prescaler_channel.sv
// One prescaler channel: counts 0..active_limit-1, pulses clock_enable on the
// terminal cycle, toggles div_clock at each wrap, periodic or one-shot.
module prescaler_channel
   import prescaler_pkg::*;
#(
   parameter int PRESCALER_WIDTH = 8
) (
   input  logic                       clock,
   input  logic                       rst_n,
   input  logic                       enable,
   input  logic                       mode,
   input  logic                       start,
   input  logic                       load,
   input  logic [PRESCALER_WIDTH-1:0] limit,
   output logic                       clock_enable,
   output logic                       div_clock,
   output logic                       busy
);

   localparam int W = PRESCALER_WIDTH;

   state_t       state_q, state_d;
   mode_t        mode_q, mode_d;
   logic [W-1:0] count_q, count_d;
   logic [W-1:0] shadow_q, shadow_d;
   logic [W-1:0] active_q, active_d;
   logic         ce_q, ce_d;
   logic         div_q, div_d;
   logic         term;

   // Widened by one bit so cnt+1 never wraps; a limit of 0 therefore never matches.
   function automatic logic is_last(input logic [W-1:0] cnt, input logic [W-1:0] lim);
      return (({1'b0, cnt} + (W+1)'(1)) == {1'b0, lim});
   endfunction

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         mode_q   <= PERIODIC;
         count_q  <= '0;
         shadow_q <= '0;
         active_q <= '0;
         ce_q     <= 1'b0;
         div_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         count_q  <= count_d;
         shadow_q <= shadow_d;
         active_q <= active_d;
         ce_q     <= ce_d;
         div_q    <= div_d;
      end
   end

   always_comb begin
      term     = (state_q == RUN) && is_last(count_q, active_q);
      state_d  = state_q;
      mode_d   = mode_q;
      count_d  = count_q;
      shadow_d = load ? limit : shadow_q;
      active_d = active_q;
      div_d    = div_q ^ term;
      // The live limit only changes between periods, so a mid-period load never cuts one short.
      if ((state_q == IDLE) || term) begin
         active_d = load ? limit : shadow_q;
      end
      if (!enable) begin
         state_d = IDLE;
         count_d = '0;
      end else if (state_q == IDLE) begin
         if ((active_d != '0) && ((mode_t'(mode) == PERIODIC) || start)) begin
            state_d = RUN;
            mode_d  = mode_t'(mode);
            count_d = '0;
         end
      end else if (term) begin
         count_d = '0;
         if ((mode_q == ONE_SHOT) || (active_d == '0)) begin
            state_d = IDLE;
         end
      end else begin
         count_d = count_q + W'(1);
      end
      // Registered pulse: computed from the values the count/limit take at this edge.
      ce_d = (state_d == RUN) && is_last(count_d, active_d);
   end

   always_comb begin
      clock_enable = ce_q;
      div_clock    = div_q;
      busy         = (state_q == RUN);
   end

endmodule

// File: rtl/prescaler_bank.sv
// Bank of NUM_CH independent prescaler channels sharing one clock and one
// reset whose release is synchronised so every channel starts on the same edge.
module prescaler_bank
   import prescaler_pkg::*;
#(
   parameter int NUM_CH          = 4,
   parameter int PRESCALER_WIDTH = 8
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic [NUM_CH-1:0]                 enable,
   input  logic [NUM_CH-1:0]                 mode,
   input  logic [NUM_CH-1:0]                 start,
   input  logic [NUM_CH-1:0]                 load,
   input  logic [NUM_CH*PRESCALER_WIDTH-1:0] limit,
   output logic [NUM_CH-1:0]                 clock_enable,
   output logic [NUM_CH-1:0]                 div_clock,
   output logic [NUM_CH-1:0]                 busy
);

   logic [1:0] rst_sync_q, rst_sync_d;
   logic       rst_sync_n;

   // Assert asynchronously (reset is active-low), release two edges later for all channels at once.
   always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rst_sync_q <= '0;
      end else begin
         rst_sync_q <= rst_sync_d;
      end
   end

   assign rst_sync_n = rst_sync_q[1];

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      prescaler_channel #(
         .PRESCALER_WIDTH(PRESCALER_WIDTH)
      ) u_ch (
         .clock        (clock),
         .rst_n        (rst_sync_n),
         .enable       (enable[g]),
         .mode         (mode[g]),
         .start        (start[g]),
         .load         (load[g]),
         .limit        (limit[g*PRESCALER_WIDTH +: PRESCALER_WIDTH]),
         .clock_enable (clock_enable[g]),
         .div_clock    (div_clock[g]),
         .busy         (busy[g])
      );
   end

endmodule

// File: tb/tb_prescaler_bank.sv
// Bench for prescaler_bank: directed scenarios with hand-derived pulse timing
// plus a randomized run, all cross-checked against a period-based reference model.
module tb_prescaler_bank;

   localparam int NCH = 4;
   localparam int W   = 8;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic [NCH-1:0]   enable, mode, start, load;
   logic [NCH*W-1:0] limit;
   logic [NCH-1:0]   clock_enable, div_clock, busy;

   int tests = 0;
   int fails = 0;

   // Reference model: per channel, whether it runs, how many cycles of the current period have elapsed.
   bit m_run[NCH];
   bit m_os[NCH];
   bit m_div[NCH];
   int m_el[NCH];
   int m_act[NCH];
   int m_sh[NCH];
   int rel_edges = 0;

   prescaler_bank #(.NUM_CH(NCH), .PRESCALER_WIDTH(W)) dut (
      .clock        (clock),
      .reset        (reset),
      .enable       (enable),
      .mode         (mode),
      .start        (start),
      .load         (load),
      .limit        (limit),
      .clock_enable (clock_enable),
      .div_clock    (div_clock),
      .busy         (busy)
   );

   always #5 clock = ~clock;

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_run[c] = 0; m_os[c] = 0; m_div[c] = 0;
         m_el[c] = 0; m_act[c] = 0; m_sh[c] = 0;
      end
      rel_edges = 0;
   endtask

   task automatic model_edge();
      for (int c = 0; c < NCH; c++) begin
         int lim;
         int nxt;
         bit fin;
         lim = int'(limit[c*W +: W]);
         fin = m_run[c] && (m_el[c] == m_act[c]);
         nxt = (!m_run[c] || fin) ? (load[c] ? lim : m_sh[c]) : m_act[c];
         if (load[c]) m_sh[c] = lim;
         if (fin) m_div[c] = !m_div[c];
         if (!enable[c]) begin
            m_run[c] = 0;
         end else if (!m_run[c]) begin
            if (nxt > 0 && (!mode[c] || start[c])) begin
               m_run[c] = 1; m_os[c] = mode[c]; m_el[c] = 1;
            end
         end else if (fin) begin
            if (m_os[c] || nxt == 0) m_run[c] = 0;
            else m_el[c] = 1;
         end else begin
            m_el[c] = m_el[c] + 1;
         end
         m_act[c] = nxt;
      end
   endtask

   function automatic logic [3*NCH-1:0] exp_all();
      logic [NCH-1:0] e_ce, e_busy, e_div;
      for (int c = 0; c < NCH; c++) begin
         e_ce[c]   = m_run[c] && (m_el[c] == m_act[c]);
         e_busy[c] = m_run[c];
         e_div[c]  = m_div[c];
      end
      return {e_ce, e_busy, e_div};
   endfunction

   task automatic tick();
      @(posedge clock);
      if (!reset) rel_edges = 0;
      else if (rel_edges < 3) rel_edges++;
      if (reset && rel_edges >= 3) model_edge();
      #1;
   endtask

   task automatic test_reset();
      #1;
      tests++;
      if ({clock_enable, busy, div_clock} !== '0) begin
         fails++;
         $display("FAIL reset_immediate got=%h want=0", {clock_enable, busy, div_clock});
      end
      tick(); tick();
      tests++;
      if ({clock_enable, busy, div_clock} !== '0) begin
         fails++;
         $display("FAIL reset_held got=%h want=0", {clock_enable, busy, div_clock});
      end
      #2 reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         tests++;
         if ({clock_enable, busy, div_clock} !== exp_all()) begin
            fails++;
            $display("FAIL reset_model cyc=%0d got=%h want=%h", i, {clock_enable, busy, div_clock}, exp_all());
         end
      end
   endtask

   task automatic test_periodic();
      int pulses = 0;
      limit[0 +: W] = 8'd5; load[0] = 1'b1; enable[0] = 1'b1; mode[0] = 1'b0;
      tick();
      load[0] = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         tests++;
         if (clock_enable[0] !== (i % 5 == 0)) begin
            fails++;
            $display("FAIL periodic_ce cyc=%0d got=%b want=%b", i, clock_enable[0], (i % 5 == 0));
         end
         tests++;
         if (div_clock[0] !== (((i - 1) / 5) % 2 == 1)) begin
            fails++;
            $display("FAIL periodic_div cyc=%0d got=%b want=%b", i, div_clock[0], (((i - 1) / 5) % 2 == 1));
         end
         tests++;
         if ({clock_enable, busy, div_clock} !== exp_all()) begin
            fails++;
            $display("FAIL periodic_model cyc=%0d got=%h want=%h", i, {clock_enable, busy, div_clock}, exp_all());
         end
         if (clock_enable[0]) pulses++;
         tick();
      end
      tests++;
      if (pulses != 8) begin
         fails++;
         $display("FAIL periodic_count got=%0d want=8", pulses);
      end
      enable[0] = 1'b0;
      tick();
   endtask

   task automatic test_oneshot();
      int pulses = 0;
      mode[1] = 1'b1; limit[W +: W] = 8'd3; load[1] = 1'b1; enable[1] = 1'b1; start[1] = 1'b0;
      tick();
      load[1] = 1'b0;
      tests++;
      if (busy[1] !== 1'b0) begin
         fails++;
         $display("FAIL oneshot_wait got=%b want=0", busy[1]);
      end
      start[1] = 1'b1;
      tick();
      start[1] = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         tests++;
         if (clock_enable[1] !== (i == 3)) begin
            fails++;
            $display("FAIL oneshot_ce cyc=%0d got=%b want=%b", i, clock_enable[1], (i == 3));
         end
         tests++;
         if (busy[1] !== (i <= 3)) begin
            fails++;
            $display("FAIL oneshot_busy cyc=%0d got=%b want=%b", i, busy[1], (i <= 3));
         end
         tests++;
         if ({clock_enable, busy, div_clock} !== exp_all()) begin
            fails++;
            $display("FAIL oneshot_model cyc=%0d got=%h want=%h", i, {clock_enable, busy, div_clock}, exp_all());
         end
         if (clock_enable[1]) pulses++;
         start[1] = (i == 2);
         tick();
      end
      tests++;
      if (pulses != 1) begin
         fails++;
         $display("FAIL oneshot_count got=%0d want=1", pulses);
      end
      enable[1] = 1'b0; mode[1] = 1'b0;
      tick();
   endtask

   task automatic test_reload();
      limit[0 +: W] = 8'd8; load[0] = 1'b1; enable[0] = 1'b1;
      tick();
      load[0] = 1'b0;
      for (int i = 1; i <= 17; i++) begin
         tests++;
         if (clock_enable[0] !== (i == 8 || i == 11 || i == 14 || i == 17)) begin
            fails++;
            $display("FAIL reload_ce cyc=%0d got=%b want=%b", i, clock_enable[0], (i == 8 || i == 11 || i == 14 || i == 17));
         end
         tests++;
         if ({clock_enable, busy, div_clock} !== exp_all()) begin
            fails++;
            $display("FAIL reload_model cyc=%0d got=%h want=%h", i, {clock_enable, busy, div_clock}, exp_all());
         end
         if (i == 3) begin
            limit[0 +: W] = 8'd3; load[0] = 1'b1;
         end else begin
            load[0] = 1'b0;
         end
         tick();
      end
      enable[0] = 1'b0;
      tick();
   endtask

   task automatic test_limit_edges();
      limit[2*W +: W] = 8'd1; load[2] = 1'b1; enable[2] = 1'b1;
      tick();
      load[2] = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         tests++;
         if ({clock_enable[2], busy[2]} !== 2'b11) begin
            fails++;
            $display("FAIL limit1_ce_busy cyc=%0d got=%b want=11", i, {clock_enable[2], busy[2]});
         end
         tests++;
         if ({clock_enable, busy, div_clock} !== exp_all()) begin
            fails++;
            $display("FAIL limit1_model cyc=%0d got=%h want=%h", i, {clock_enable, busy, div_clock}, exp_all());
         end
         tick();
      end
      enable[2] = 1'b0; limit[2*W +: W] = 8'd0; load[2] = 1'b1;
      tick();
      load[2] = 1'b0; enable[2] = 1'b1;
      for (int i = 1; i <= 50; i++) begin
         tick();
         tests++;
         if ({clock_enable[2], busy[2]} !== 2'b00) begin
            fails++;
            $display("FAIL limit0_idle cyc=%0d got=%b want=00", i, {clock_enable[2], busy[2]});
         end
      end
      enable[2] = 1'b0;
      tick();
   endtask

   task automatic test_all_channels();
      int cnt[NCH];
      int want[NCH];
      want = '{42, 28, 21, 12};
      enable = '0;
      tick();
      limit = {8'd7, 8'd4, 8'd3, 8'd2};
      load = '1; mode = '0; enable = '1;
      tick();
      load = '0;
      for (int c = 0; c < NCH; c++) cnt[c] = 0;
      for (int i = 1; i <= 84; i++) begin
         tests++;
         if ({clock_enable, busy, div_clock} !== exp_all()) begin
            fails++;
            $display("FAIL allch_model cyc=%0d got=%h want=%h", i, {clock_enable, busy, div_clock}, exp_all());
         end
         for (int c = 0; c < NCH; c++) if (clock_enable[c]) cnt[c]++;
         tick();
      end
      for (int c = 0; c < NCH; c++) begin
         tests++;
         if (cnt[c] != want[c]) begin
            fails++;
            $display("FAIL allch_count ch=%0d got=%0d want=%0d", c, cnt[c], want[c]);
         end
      end
   endtask

   task automatic test_reset_midrun();
      tick(); tick();
      tests++;
      if (busy !== {NCH{1'b1}}) begin
         fails++;
         $display("FAIL midrun_busy_before got=%b want=%b", busy, {NCH{1'b1}});
      end
      #3 reset = 1'b0;
      model_reset();
      #1;
      tests++;
      if ({clock_enable, busy, div_clock} !== '0) begin
         fails++;
         $display("FAIL midrun_async_clear got=%h want=0", {clock_enable, busy, div_clock});
      end
      tick(); tick();
      #2 reset = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         tests++;
         if ({clock_enable, busy} !== '0) begin
            fails++;
            $display("FAIL midrun_no_restart cyc=%0d got=%h want=0", i, {clock_enable, busy});
         end
      end
      limit = {NCH{8'd2}};
      load = '1;
      tick();
      load = '0;
      for (int i = 1; i <= 6; i++) begin
         tests++;
         if (clock_enable !== ((i % 2 == 0) ? {NCH{1'b1}} : {NCH{1'b0}})) begin
            fails++;
            $display("FAIL midrun_restart_ce cyc=%0d got=%b", i, clock_enable);
         end
         tests++;
         if ({clock_enable, busy, div_clock} !== exp_all()) begin
            fails++;
            $display("FAIL midrun_model cyc=%0d got=%h want=%h", i, {clock_enable, busy, div_clock}, exp_all());
         end
         tick();
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         for (int c = 0; c < NCH; c++) begin
            enable[c]        = ($urandom_range(0, 15) != 0);
            mode[c]          = 1'($urandom_range(0, 1));
            start[c]         = ($urandom_range(0, 3) == 0);
            load[c]          = ($urandom_range(0, 5) == 0);
            limit[c*W +: W]  = W'($urandom_range(0, 6));
         end
         tick();
         tests++;
         if ({clock_enable, busy, div_clock} !== exp_all()) begin
            fails++;
            $display("FAIL random_model n=%0d got=%h want=%h", n, {clock_enable, busy, div_clock}, exp_all());
         end
      end
   endtask

   initial begin
      enable = '0; mode = '0; start = '0; load = '0; limit = '0;
      #2 reset = 1'b0;
      model_reset();
      test_reset();
      test_periodic();
      test_oneshot();
      test_reload();
      test_limit_edges();
      test_all_channels();
      test_reset_midrun();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
